// File: rtl/l1_dcache_ctrl.sv
// Blocking L1 D-cache miss controller: lookup, round-robin victim, dirty writeback, refill, replay.
// Hit latency 2 cycles (accept N, resp N+2); req_ready low while busy; mem requests held until mem_req_ready.
// Optional DCACHE_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module l1_dcache_ctrl #(
    parameter int DATA_LENGTH = 32,
    parameter int CACHE_SIZE  = 49152,
    parameter int LINE_SIZE   = 64,
    parameter int WAYS        = 12,
    localparam int OFFSET_W   = $clog2(LINE_SIZE),
    localparam int INDEX_W    = $clog2(CACHE_SIZE / (LINE_SIZE * WAYS)),
    localparam int TAG_W      = 32 - OFFSET_W - INDEX_W,
    localparam int WAY_W      = $clog2(WAYS),
    localparam int LINE_W     = LINE_SIZE * 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [31:0]            req_addr,
    input  logic [DATA_LENGTH-1:0] req_wdata,
    output logic                   resp_valid,
    output logic [DATA_LENGTH-1:0] resp_rdata,
    output logic                   query_valid,
    output logic [31:0]            query_addr,
    input  logic                   query_hit,
    input  logic [WAY_W-1:0]       query_hit_way,
    input  logic [DATA_LENGTH-1:0] query_data_out,
    output logic                   do_store,
    output logic [WAY_W-1:0]       store_way,
    output logic [31:0]            store_addr,
    output logic [DATA_LENGTH-1:0] store_data_in,
    output logic                   do_update_line,
    output logic                   do_update_tag_and_valid,
    output logic                   do_clear_dirty,
    output logic                   update_dirty_bit,
    output logic [31:0]            update_addr,
    output logic [WAY_W-1:0]       update_way,
    output logic [LINE_W-1:0]      update_line_data,
    output logic [WAY_W-1:0]       victim_way,
    output logic [31:0]            victim_addr,
    input  logic [31:0]            victim_tag_out,
    input  logic                   victim_dirty_out,
    input  logic [LINE_W-1:0]      victim_line_data_out,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_we,
    output logic [31:0]            mem_req_addr,
    output logic [LINE_W-1:0]      mem_wdata,
    input  logic                   mem_resp_valid,
    input  logic [LINE_W-1:0]      mem_rdata
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]            perf_hits,
    output logic [31:0]            perf_misses,
    output logic [31:0]            perf_wbs
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOOKUP  = 3'd1;
    localparam logic [2:0] S_RESP    = 3'd2;
    localparam logic [2:0] S_WB_REQ  = 3'd3;
    localparam logic [2:0] S_RF_REQ  = 3'd4;
    localparam logic [2:0] S_RF_WAIT = 3'd5;
    localparam logic [2:0] S_FILL    = 3'd6;

    logic [2:0]             state, state_nxt;
    logic                   we_q;
    logic [31:0]            addr_q;
    logic [DATA_LENGTH-1:0] wdata_q;
    logic [DATA_LENGTH-1:0] rdata_q;
    logic [WAY_W-1:0]       hit_way_q;
    logic [WAY_W-1:0]       rr_ptr, rr_nxt;
    logic [31:0]            wb_addr_q;
    logic [LINE_W-1:0]      line_q;
    logic                   replay_q;
    logic [31:0]            line_addr;
    logic                   unused_tag_hi;

    assign line_addr     = {addr_q[31:OFFSET_W], {OFFSET_W{1'b0}}};
    assign rr_nxt        = (rr_ptr == WAY_W'(WAYS - 1)) ? '0 : rr_ptr + 1'b1;
    assign unused_tag_hi = |victim_tag_out[31:TAG_W];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (req_valid) state_nxt = S_LOOKUP;
            S_LOOKUP:  if (query_hit) state_nxt = S_RESP;
                       else if (victim_dirty_out) state_nxt = S_WB_REQ;
                       else state_nxt = S_RF_REQ;
            S_RESP:    state_nxt = S_IDLE;
            S_WB_REQ:  if (mem_req_ready) state_nxt = S_RF_REQ;
            S_RF_REQ:  if (mem_req_ready) state_nxt = S_RF_WAIT;
            S_RF_WAIT: if (mem_resp_valid) state_nxt = S_FILL;
            S_FILL:    state_nxt = S_LOOKUP;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // The victim line and the refill line never live at the same time, so they share line_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            hit_way_q <= '0;
            rr_ptr    <= '0;
            wb_addr_q <= '0;
            line_q    <= '0;
            replay_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (req_valid) begin
                    we_q    <= req_we;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                end
                S_LOOKUP: begin
                    replay_q <= 1'b0;
                    if (query_hit) begin
                        hit_way_q <= query_hit_way;
                        rdata_q   <= query_data_out;
                    end else if (victim_dirty_out) begin
                        line_q    <= victim_line_data_out;
                        wb_addr_q <= {victim_tag_out[TAG_W-1:0],
                                      addr_q[OFFSET_W+INDEX_W-1:OFFSET_W],
                                      {OFFSET_W{1'b0}}};
                    end
                end
                S_RF_WAIT: if (mem_resp_valid) line_q <= mem_rdata;
                S_FILL: begin
                    rr_ptr   <= rr_nxt;
                    replay_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready     = (state == S_IDLE) && !rst;
    assign resp_valid    = (state == S_RESP);
    assign resp_rdata    = (state == S_RESP && !we_q) ? rdata_q : '0;
    assign query_valid   = (state == S_LOOKUP);
    assign query_addr    = (state == S_LOOKUP) ? addr_q : '0;
    assign do_store      = (state == S_RESP) && we_q;
    assign store_way     = hit_way_q;
    assign store_addr    = addr_q;
    assign store_data_in = wdata_q;

    assign do_update_line          = (state == S_FILL);
    assign do_update_tag_and_valid = (state == S_FILL);
    assign do_clear_dirty          = (state == S_FILL);
    assign update_dirty_bit        = 1'b0;
    assign update_addr             = addr_q;
    assign update_way              = rr_ptr;
    assign update_line_data        = line_q;
    assign victim_way              = rr_ptr;
    assign victim_addr             = addr_q;

    assign mem_req_valid = (state == S_WB_REQ) || (state == S_RF_REQ);
    assign mem_req_we    = (state == S_WB_REQ);
    assign mem_req_addr  = (state == S_WB_REQ) ? wb_addr_q :
                           (state == S_RF_REQ) ? line_addr : '0;
    assign mem_wdata     = (state == S_WB_REQ) ? line_q : '0;

`ifdef DCACHE_PERF_CNT_EN
    // Replay lookups after a fill are not counted as hits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_wbs    <= '0;
        end else begin
            if (state == S_LOOKUP && query_hit && !replay_q && perf_hits != '1)
                perf_hits <= perf_hits + 1'b1;
            if (state == S_LOOKUP && !query_hit && perf_misses != '1)
                perf_misses <= perf_misses + 1'b1;
            if (state == S_WB_REQ && mem_req_ready && perf_wbs != '1)
                perf_wbs <= perf_wbs + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Directed bench for l1_dcache_ctrl with a behavioural cache core, a line memory and scoreboards.
module tb_l1_dcache_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_we;
    logic [31:0]  req_addr, req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         query_valid;
    logic [31:0]  query_addr;
    logic         query_hit;
    logic [3:0]   query_hit_way;
    logic [31:0]  query_data_out;
    logic         do_store;
    logic [3:0]   store_way;
    logic [31:0]  store_addr, store_data_in;
    logic         do_update_line, do_update_tag_and_valid, do_clear_dirty, update_dirty_bit;
    logic [31:0]  update_addr;
    logic [3:0]   update_way;
    logic [511:0] update_line_data;
    logic [3:0]   victim_way;
    logic [31:0]  victim_addr, victim_tag_out;
    logic         victim_dirty_out;
    logic [511:0] victim_line_data_out;
    logic         mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [511:0] mem_wdata;
    logic         mem_resp_valid;
    logic [511:0] mem_rdata;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  perf_hits, perf_misses, perf_wbs;
`endif

    always #5 clk = ~clk;

    l1_dcache_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .query_valid(query_valid), .query_addr(query_addr),
        .query_hit(query_hit), .query_hit_way(query_hit_way), .query_data_out(query_data_out),
        .do_store(do_store), .store_way(store_way), .store_addr(store_addr),
        .store_data_in(store_data_in),
        .do_update_line(do_update_line), .do_update_tag_and_valid(do_update_tag_and_valid),
        .do_clear_dirty(do_clear_dirty), .update_dirty_bit(update_dirty_bit),
        .update_addr(update_addr), .update_way(update_way), .update_line_data(update_line_data),
        .victim_way(victim_way), .victim_addr(victim_addr),
        .victim_tag_out(victim_tag_out), .victim_dirty_out(victim_dirty_out),
        .victim_line_data_out(victim_line_data_out),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
        .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
        , .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_wbs(perf_wbs)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] data; int cyc; } resp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] w; } memx_t;
    typedef struct { logic [3:0] way; logic [31:0] addr; logic [31:0] data; } st_t;
    resp_t exp_resp[$];
    memx_t exp_mem[$];
    st_t   exp_store[$];
    int    exp_fill[$];

    // Behavioural cache core: 64 sets x 12 ways, one data word per line.
    logic [19:0] c_tag [64][12];
    bit          c_vld [64][12];
    bit          c_drt [64][12];
    logic [31:0] c_dat [64][12];
    bit          init_done = 1'b0;

    always_comb begin
        query_hit            = 1'b0;
        query_hit_way        = '0;
        query_data_out       = '0;
        victim_tag_out       = '0;
        victim_dirty_out     = 1'b0;
        victim_line_data_out = '0;
        for (int w = 0; w < 12; w++) begin
            if (c_vld[query_addr[11:6]][w] && c_tag[query_addr[11:6]][w] == query_addr[31:12]) begin
                query_hit      = 1'b1;
                query_hit_way  = 4'(w);
                query_data_out = c_dat[query_addr[11:6]][w];
            end
        end
        if (victim_way < 4'd12) begin
            victim_tag_out       = {12'h0, c_tag[victim_addr[11:6]][victim_way]};
            victim_dirty_out     = c_vld[victim_addr[11:6]][victim_way] && c_drt[victim_addr[11:6]][victim_way];
            victim_line_data_out = {16{c_dat[victim_addr[11:6]][victim_way]}};
        end
    end

    always @(posedge clk) begin
        if (!init_done) begin
            for (int s = 0; s < 64; s++)
                for (int w = 0; w < 12; w++) begin
                    c_tag[s][w] <= '0; c_vld[s][w] <= 1'b0; c_drt[s][w] <= 1'b0; c_dat[s][w] <= '0;
                end
            c_tag[0][3] <= 20'h1;     c_vld[0][3] <= 1'b1; c_dat[0][3] <= 32'hDEADBEEF;
            c_tag[0][7] <= 20'h2;     c_vld[0][7] <= 1'b1; c_dat[0][7] <= 32'h11111111;
            c_tag[1][1] <= 20'h12345; c_vld[1][1] <= 1'b1; c_drt[1][1] <= 1'b1; c_dat[1][1] <= 32'hBADC0FFE;
            init_done <= 1'b1;
        end else begin
            if (do_update_line && update_way < 4'd12) begin
                c_tag[update_addr[11:6]][update_way] <= update_addr[31:12];
                c_vld[update_addr[11:6]][update_way] <= 1'b1;
                c_drt[update_addr[11:6]][update_way] <= update_dirty_bit;
                c_dat[update_addr[11:6]][update_way] <= update_line_data[31:0];
            end
            if (do_store && store_way < 4'd12) begin
                c_dat[store_addr[11:6]][store_way] <= store_data_in;
                c_drt[store_addr[11:6]][store_way] <= 1'b1;
            end
        end
    end

    // Output monitor: responses, stores and fills against their scoreboards.
    resp_t m_r;
    st_t   m_s;
    int    m_f;
    always @(negedge clk) begin
        if (!rst) begin
            if (resp_valid) begin
                check("resp_expected", exp_resp.size() > 0, 1);
                if (exp_resp.size() > 0) begin
                    m_r = exp_resp.pop_front();
                    check("resp_rdata", resp_rdata, m_r.data);
                    if (m_r.cyc >= 0) check("resp_cycle", cyc, m_r.cyc);
                end
            end
            if (do_store) begin
                check("store_expected", exp_store.size() > 0, 1);
                if (exp_store.size() > 0) begin
                    m_s = exp_store.pop_front();
                    check("store_way", store_way, m_s.way);
                    check("store_addr", store_addr, m_s.addr);
                    check("store_data", store_data_in, m_s.data);
                end
            end
            if (do_update_line) begin
                check("fill_expected", exp_fill.size() > 0, 1);
                check("fill_tag_valid", do_update_tag_and_valid, 1);
                check("fill_clear_dirty", do_clear_dirty, 1);
                check("fill_dirty_bit", update_dirty_bit, 0);
                if (exp_fill.size() > 0) begin
                    m_f = exp_fill.pop_front();
                    check("fill_way", update_way, m_f);
                end
            end
        end
    end

    // Line memory: programmable ready delay, read data returns two cycles after accept.
    int          mem_dly = 0;
    bit          hs;
    logic        hs_we, held_we;
    logic [31:0] hs_addr, hs_lo, hs_hi, held_addr, raddr;
    int          wcnt, rcnt;
    memx_t       mx;
    always @(negedge clk) begin
        mem_resp_valid = 1'b0;
        if (rst) begin
            mem_req_ready = 1'b0; hs = 1'b0; wcnt = 0; rcnt = 0; mem_rdata = '0;
        end else begin
            if (rcnt > 0) begin
                rcnt--;
                if (rcnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_rdata      = {16{raddr ^ 32'hF00D0000}};
                end
            end
            if (hs) begin
                check("mem_expected", exp_mem.size() > 0, 1);
                if (exp_mem.size() > 0) begin
                    mx = exp_mem.pop_front();
                    check("mem_we", hs_we, mx.we);
                    check("mem_addr", hs_addr, mx.addr);
                    if (mx.we) begin
                        check("wb_data_lo", hs_lo, mx.w);
                        check("wb_data_hi", hs_hi, mx.w);
                        check("wb_no_gap", mem_req_valid, 1);
                    end else begin
                        rcnt  = 2;
                        raddr = hs_addr;
                    end
                end
                hs = 1'b0; mem_req_ready = 1'b0; wcnt = 0;
            end
            if (mem_req_valid && !mem_req_ready) begin
                if (wcnt == 0) begin
                    held_we = mem_req_we; held_addr = mem_req_addr;
                end else begin
                    check("mem_hold_addr", mem_req_addr, held_addr);
                    check("mem_hold_we", mem_req_we, held_we);
                end
                if (wcnt >= mem_dly) mem_req_ready = 1'b1;
                wcnt++;
            end
            if (mem_req_valid && mem_req_ready) begin
                hs = 1'b1; hs_we = mem_req_we; hs_addr = mem_req_addr;
                hs_lo = mem_wdata[31:0]; hs_hi = mem_wdata[511:480];
            end
        end
    end

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd, output int acc);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        check("req_accept_bound", t < 200, 1);
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic push_miss(input logic we, input logic [31:0] addr, input logic [31:0] wd, input int way);
        memx_t m; resp_t r; st_t s;
        m.we = 1'b0; m.addr = {addr[31:6], 6'h0}; m.w = '0;
        exp_mem.push_back(m);
        exp_fill.push_back(way);
        if (we) begin
            s.way = 4'(way); s.addr = addr; s.data = wd;
            exp_store.push_back(s);
        end
        r.data = we ? 32'h0 : ({addr[31:6], 6'h0} ^ 32'hF00D0000);
        r.cyc  = -1;
        exp_resp.push_back(r);
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((exp_resp.size() != 0 || exp_mem.size() != 0 || exp_fill.size() != 0 ||
                exp_store.size() != 0) && t < 500) begin
            @(negedge clk); t++;
        end
        check(tag, t < 500, 1);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    acc;
        int    t;
        resp_t r0;
        st_t   s0;
        memx_t m0;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_do_update", do_update_line, 0);
        check("rst_do_store", do_store, 0);
        check("rst_query_valid", query_valid, 0);
        check("rst_victim_way", victim_way, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_req_ready", req_ready, 1);

        // Load hit on way 3
        send(1'b0, 32'h0000_1004, 32'h0, acc);
        r0.data = 32'hDEADBEEF; r0.cyc = acc + 2; exp_resp.push_back(r0);
        check("lookup_req_ready", req_ready, 0);
        @(negedge clk);
        @(negedge clk);
        check("hit_next_accept", req_ready, 1);
        check("hit_resp_done", exp_resp.size(), 0);

        // Store hit on way 7
        send(1'b1, 32'h0000_2008, 32'hA5A5A5A5, acc);
        r0.data = 32'h0; r0.cyc = acc + 2; exp_resp.push_back(r0);
        s0.way = 4'd7; s0.addr = 32'h0000_2008; s0.data = 32'hA5A5A5A5; exp_store.push_back(s0);
        drain("store_hit_drain");

        // Clean miss with delayed mem_req_ready, then a second request to the same line
        mem_dly = 3;
        push_miss(1'b0, 32'h0001_0040, 32'h0, 0);
        send(1'b0, 32'h0001_0040, 32'h0, acc);
        drain("clean_miss_drain");
        check("rr_after_miss", victim_way, 1);
        send(1'b0, 32'h0001_0048, 32'h0, acc);
        r0.data = 32'h0001_0040 ^ 32'hF00D0000; r0.cyc = acc + 2; exp_resp.push_back(r0);
        drain("same_line_drain");

        // Dirty miss: writeback of victim tag 0x12345 at index 1, then refill
        mem_dly = 0;
        m0.we = 1'b1; m0.addr = 32'h1234_5040; m0.w = 32'hBADC0FFE; exp_mem.push_back(m0);
        push_miss(1'b0, 32'h0002_0044, 32'h0, 1);
        send(1'b0, 32'h0002_0044, 32'h0, acc);
        drain("dirty_miss_drain");

        // Advance the round-robin pointer back to way 0 using set 6
        for (int i = 0; i < 10; i++) begin
            push_miss(1'b0, {20'h200 + 20'(i), 6'd6, 6'd0}, 32'h0, 2 + i);
            send(1'b0, {20'h200 + 20'(i), 6'd6, 6'd0}, 32'h0, acc);
            drain("rr_advance_drain");
        end

        // Thirteen misses in set 5: ways 0..11 then 0 again; the last one is a store
        for (int i = 0; i < 13; i++) begin
            push_miss(i == 12, {20'h100 + 20'(i), 6'd5, 6'd4}, 32'h5000 + 32'(i), i % 12);
            send(i == 12, {20'h100 + 20'(i), 6'd5, 6'd4}, 32'h5000 + 32'(i), acc);
            drain("rr_wrap_drain");
        end
        check("rr_after_wrap", victim_way, 1);

        // Reset while waiting for refill data
        push_miss(1'b0, 32'h0077_71C0, 32'h0, 1);
        send(1'b0, 32'h0077_71C0, 32'h0, acc);
        t = 0;
        while (rcnt == 0 && t < 50) begin @(negedge clk); #1; t++; end
        check("rf_wait_reached", rcnt > 0, 1);
        exp_fill.delete();
        exp_resp.delete();
        rst = 1'b1;
        #1;
        check("midmiss_rst_req_ready", req_ready, 0);
        check("midmiss_rst_update", do_update_line, 0);
        check("midmiss_rst_mem_valid", mem_req_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", req_ready, 1);
        check("post_rst_rr", victim_way, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            check("post_rst_no_fill", do_update_line, 0);
        end

        // Still functional after reset
        send(1'b0, 32'h0000_1004, 32'h0, acc);
        r0.data = 32'hDEADBEEF; r0.cyc = acc + 2; exp_resp.push_back(r0);
        drain("final_hit_drain");
        check("sb_mem_empty", exp_mem.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
